udm_split_ram: RTL and testbench

- Split-transaction bus slave with internal word-addressed RAM.
- Sits directly downstream of the UDM split-bus adapter and consumes its req/we/addr/be/wdata → ack, resp/rdata bus.
- Main uses: on-chip debug scratch memory, and a configurable-latency target for exercising the adapter's read-tracking logic.
- Wait states before ack and read-response latency are both parameterised.

---
 rtl/udm_split_ram_if.sv | 22 ++
 rtl/udm_split_ram.sv | 106 ++++++++++
 tb/tb_udm_split_ram.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/udm_split_ram_if.sv
// Split-transaction bus between the UDM adapter (master) and a RAM target (slave).
// Signal names follow the slave's point of view.
interface udm_split_ram_if;
  logic        bus_req_i;
  logic        bus_we_i;
  logic [31:0] bus_addr_bi;
  logic [3:0]  bus_be_bi;
  logic [31:0] bus_wdata_bi;
  logic        bus_ack_o;
  logic        bus_resp_o;
  logic [31:0] bus_rdata_bo;

  modport master (
    output bus_req_i, bus_we_i, bus_addr_bi, bus_be_bi, bus_wdata_bi,
    input  bus_ack_o, bus_resp_o, bus_rdata_bo
  );

  modport slave (
    input  bus_req_i, bus_we_i, bus_addr_bi, bus_be_bi, bus_wdata_bi,
    output bus_ack_o, bus_resp_o, bus_rdata_bo
  );
endinterface

// File: rtl/udm_split_ram.sv
// Split-bus RAM slave: programmable wait states before ack, fixed-latency in-order
// read responses through a valid+data shift pipeline.
module udm_split_ram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ACK_WAIT   = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  udm_split_ram_if.slave   bus
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic {StIdle, StWait} state_e;

  state_e                r_state, w_state_d;
  logic [3:0]            r_cnt, w_cnt_d;
  logic                  w_ack, w_wr, w_rd;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           r_mem [Depth];
  logic [RD_LATENCY-1:0] r_vld;
  logic [31:0]           r_dat [RD_LATENCY];
  logic                  w_unused_addr;

  // Upper and byte-offset address bits are dropped, so addresses wrap modulo depth.
  assign w_idx         = bus.bus_addr_bi[ADDR_WIDTH+1:2];
  assign w_unused_addr = ^{bus.bus_addr_bi[31:ADDR_WIDTH+2], bus.bus_addr_bi[1:0]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      StIdle: begin
        if ((ACK_WAIT != 0) && bus.bus_req_i) begin
          w_state_d = StWait;
          w_cnt_d   = 4'd1;
        end
      end
      StWait: begin
        // A dropped request is a protocol violation; abandon it without access.
        if (w_ack || !bus.bus_req_i) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    w_ack = 1'b0;
    case (r_state)
      StIdle:  w_ack = (ACK_WAIT == 0) && bus.bus_req_i;
      StWait:  w_ack = bus.bus_req_i && (r_cnt == 4'(ACK_WAIT));
      default: w_ack = 1'b0;
    endcase
    w_ack = w_ack && rst_i;
  end

  assign w_wr = w_ack && bus.bus_we_i;
  assign w_rd = w_ack && !bus.bus_we_i;

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.bus_be_bi[b]) r_mem[w_idx][8*b +: 8] <= bus.bus_wdata_bi[8*b +: 8];
      end
    end
  end

  // Data stages only load behind a valid bit, so the last stage holds the previous response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= w_rd;
      if (w_rd) r_dat[0] <= r_mem[w_idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign bus.bus_ack_o    = w_ack;
  assign bus.bus_resp_o   = r_vld[RD_LATENCY-1];
  assign bus.bus_rdata_bo = r_dat[RD_LATENCY-1];

endmodule

// File: tb/tb_udm_split_ram.sv
// Randomised bench for udm_split_ram: two configurations checked against a
// word-array memory model with a queue of expected (cycle, data) responses.
module tb_udm_split_ram;

  typedef struct {
    int          cyc;
    logic [31:0] d;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  logic [31:0] mdl [2][1024];
  rsp_t        q0[$];
  rsp_t        q1[$];
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;

  udm_split_ram_if bus0 ();
  udm_split_ram_if bus1 ();

  udm_split_ram #(.ADDR_WIDTH(4), .RD_LATENCY(3), .ACK_WAIT(0)) u_dut0 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus0)
  );

  udm_split_ram #(.ADDR_WIDTH(10), .RD_LATENCY(4), .ACK_WAIT(3)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ack_wait(input int sel);
    return (sel == 0) ? 0 : 3;
  endfunction

  function automatic int rd_lat(input int sel);
    return (sel == 0) ? 3 : 4;
  endfunction

  function automatic int widx(input int sel, input logic [31:0] a);
    int aw;
    aw = (sel == 0) ? 4 : 10;
    return int'((a >> 2) & ((32'd1 << aw) - 32'd1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %08h want %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    if (sel == 0) begin
      bus0.bus_req_i = req; bus0.bus_we_i = we; bus0.bus_addr_bi = addr;
      bus0.bus_be_bi = be;  bus0.bus_wdata_bi = wd;
    end else begin
      bus1.bus_req_i = req; bus1.bus_we_i = we; bus1.bus_addr_bi = addr;
      bus1.bus_be_bi = be;  bus1.bus_wdata_bi = wd;
    end
  endtask

  function automatic logic get_ack(input int sel);
    return (sel == 0) ? bus0.bus_ack_o : bus1.bus_ack_o;
  endfunction

  // One request: ack expected exactly ACK_WAIT cycles after req rises.
  task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wd);
    int   i;
    rsp_t r;
    @(posedge clk); #1;
    drive(1 - sel, 1'b0, 1'b0, '0, '0, '0);
    drive(sel, 1'b1, we, addr, be, wd);
    for (int k = 0; k <= ack_wait(sel); k++) begin
      @(negedge clk);
      chk((k == ack_wait(sel)) ? "ack" : "ack_early", {31'b0, get_ack(sel)},
          {31'b0, k == ack_wait(sel)});
    end
    i = widx(sel, addr);
    if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) mdl[sel][i][8*b +: 8] = wd[8*b +: 8];
    end else begin
      r.cyc = cyc + rd_lat(sel);
      r.d   = mdl[sel][i];
      if (sel == 0) q0.push_back(r); else q1.push_back(r);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (n) @(posedge clk);
  endtask

  // Per-cycle response scoreboard; rdata must hold the last response between pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      logic e0, e1;
      e0 = (q0.size() > 0) && (q0[0].cyc == cyc);
      chk("resp0", {31'b0, bus0.bus_resp_o}, {31'b0, e0});
      if (e0) begin last0 = q0[0].d; void'(q0.pop_front()); end
      chk("rdata0", bus0.bus_rdata_bo, last0);
      e1 = (q1.size() > 0) && (q1[0].cyc == cyc);
      chk("resp1", {31'b0, bus1.bus_resp_o}, {31'b0, e1});
      if (e1) begin last1 = q1[0].d; void'(q1.pop_front()); end
      chk("rdata1", bus1.bus_rdata_bo, last1);
    end
  end

  initial begin
    logic [31:0] a;
    int          sel;
    drive(0, 1'b1, 1'b0, '0, '0, '0);
    drive(1, 1'b1, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack0", {31'b0, bus0.bus_ack_o}, 32'd0);
    chk("rst_ack1", {31'b0, bus1.bus_ack_o}, 32'd0);
    chk("rst_resp0", {31'b0, bus0.bus_resp_o}, 32'd0);
    chk("rst_resp1", {31'b0, bus1.bus_resp_o}, 32'd0);
    chk("rst_rdata0", bus0.bus_rdata_bo, 32'd0);
    chk("rst_rdata1", bus1.bus_rdata_bo, 32'd0);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // Preload every word that later reads may touch.
    for (int w = 0; w < 16; w++) txn(0, 1'b1, 32'(w * 4), 4'hF, $urandom);
    for (int w = 0; w < 16; w++) txn(1, 1'b1, 32'(w * 4), 4'hF, $urandom);
    idle(2);

    // Write then read back-to-back, byte enables, be=0 write, aliasing.
    txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    txn(0, 1'b0, 32'h10, 4'h0, '0);
    txn(0, 1'b1, 32'h20, 4'hF, 32'hFFFFFFFF);
    txn(0, 1'b1, 32'h20, 4'b0101, 32'h12345678);
    txn(0, 1'b0, 32'h20, 4'hF, '0);
    txn(0, 1'b1, 32'h20, 4'h0, 32'h0BADF00D);
    txn(0, 1'b0, 32'h20, 4'h0, '0);
    txn(0, 1'b1, 32'h0, 4'hF, 32'h000000A5);
    txn(0, 1'b0, 32'h40, 4'h0, '0);
    txn(0, 1'b0, 32'h43, 4'h0, '0);
    // Read then write of the same word: the read keeps the old data.
    txn(0, 1'b0, 32'h8, 4'h0, '0);
    txn(0, 1'b1, 32'h8, 4'hF, 32'h5555AAAA);
    txn(0, 1'b0, 32'h8, 4'h0, '0);
    idle(4);
    for (int w = 0; w < 4; w++) txn(0, 1'b1, 32'(w * 4), 4'hF, 32'(w + 1));
    for (int w = 0; w < 4; w++) txn(0, 1'b0, 32'(w * 4), 4'h0, '0);
    idle(5);

    // Slow target: held read, aliased address, and an abandoned request.
    txn(1, 1'b0, 32'hFFFF_F004, 4'h0, '0);
    txn(1, 1'b0, 32'h0000_1008, 4'h0, '0);
    idle(1);
    drive(1, 1'b1, 1'b0, 32'h4, 4'h0, '0);
    @(negedge clk); chk("viol_ack_a", {31'b0, bus1.bus_ack_o}, 32'd0);
    @(posedge clk); #1 drive(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk); chk("viol_ack_b", {31'b0, bus1.bus_ack_o}, 32'd0);
    txn(1, 1'b0, 32'h4, 4'h0, '0);
    idle(6);

    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 1));
      a = $urandom;
      if (sel == 1) a[11:2] = 10'($urandom_range(0, 15));
      txn(sel, 1'($urandom), a, 4'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 4)));
    end
    idle(8);

    // Reset two cycles after a read ack: the pending response must vanish.
    txn(1, 1'b0, 32'hC, 4'h0, '0);
    @(posedge clk); #1 drive(1, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk); #1 rst_n = 1'b0;
    q0.delete(); q1.delete();
    last0 = '0; last1 = '0;
    drive(0, 1'b1, 1'b0, 32'h4, 4'h0, '0);
    @(negedge clk);
    chk("rst_mid_ack0", {31'b0, bus0.bus_ack_o}, 32'd0);
    chk("rst_mid_resp1", {31'b0, bus1.bus_resp_o}, 32'd0);
    chk("rst_mid_rdata1", bus1.bus_rdata_bo, 32'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b1;
    idle(8);
    for (int w = 0; w < 16; w++) txn(1, 1'b0, 32'(w * 4), 4'h0, '0);
    for (int w = 0; w < 16; w++) txn(0, 1'b0, 32'(w * 4), 4'h0, '0);
    idle(8);

    if (q0.size() != 0 || q1.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain pending %0d/%0d want 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
